// File: rtl/circle_plot_sequencer.sv
// Midpoint circle rasteriser: walks one octant and emits the eight symmetric
// pixels of every step as valid/ready write requests to a pixel memory.
module circle_plot_sequencer #(
  parameter int COORD_W = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  input  logic [COORD_W-1:0] radius,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               px_valid,
  input  logic               px_ready,
  output logic [COORD_W-1:0] px_x,
  output logic [COORD_W-1:0] px_y
);

  localparam int EW = COORD_W + 3;
  localparam logic signed [EW-1:0] ONE_S = EW'(1);

  typedef enum logic [1:0] {IDLE, EMIT, STEP, DONE} state_t;

  state_t                  state_q, state_d;
  logic [COORD_W-1:0]      cx_q, cx_d, cy_q, cy_d;
  logic [COORD_W-1:0]      x_q, x_d, y_q, y_d;
  logic signed [EW-1:0]    err_q, err_d;
  logic [2:0]              k_q, k_d;
  logic [COORD_W-1:0]      pxX_q, pxX_d, pxY_q, pxY_d;
  logic signed [EW-1:0]    xExt, yExt, xDec, yInc, xNew;

  // x is widened and kept signed so that x-1 below zero (radius 0) ends the circle
  // instead of wrapping to a huge unsigned value.
  always_comb begin
    xExt = $signed({3'b000, x_q});
    yExt = $signed({3'b000, y_q});
    xDec = xExt - ONE_S;
    yInc = yExt + ONE_S;
    xNew = err_q[EW-1] ? xExt : xDec;
  end

  // Next-state logic; the pixel registers are loaded from the next-state
  // values so they already hold the point that belongs to the next octant.
  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    x_d     = x_q;
    y_d     = y_q;
    err_d   = err_q;
    k_d     = k_q;
    pxX_d   = pxX_q;
    pxY_d   = pxY_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          cx_d    = cx;
          cy_d    = cy;
          x_d     = radius;
          y_d     = '0;
          err_d   = ONE_S - $signed({3'b000, radius});
          k_d     = 3'd0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (px_ready) begin
          k_d = k_q + 3'd1;
          if (k_q == 3'd7) state_d = STEP;
        end
      end
      STEP: begin
        y_d = yInc[COORD_W-1:0];
        if (err_q[EW-1]) begin
          err_d = err_q + (yInc <<< 1) + ONE_S;
        end else begin
          x_d   = xDec[COORD_W-1:0];
          err_d = err_q + ((yInc - xDec) <<< 1) + ONE_S;
        end
        k_d     = 3'd0;
        state_d = (xNew >= yInc) ? EMIT : DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      k_d     = 3'd0;
    end

    case (k_d)
      3'd0: begin pxX_d = cx_d + x_d; pxY_d = cy_d + y_d; end
      3'd1: begin pxX_d = cx_d + x_d; pxY_d = cy_d - y_d; end
      3'd2: begin pxX_d = cx_d - x_d; pxY_d = cy_d + y_d; end
      3'd3: begin pxX_d = cx_d - x_d; pxY_d = cy_d - y_d; end
      3'd4: begin pxX_d = cx_d + y_d; pxY_d = cy_d + x_d; end
      3'd5: begin pxX_d = cx_d + y_d; pxY_d = cy_d - x_d; end
      3'd6: begin pxX_d = cx_d - y_d; pxY_d = cy_d + x_d; end
      default: begin pxX_d = cx_d - y_d; pxY_d = cy_d - x_d; end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      err_q   <= '0;
      k_q     <= 3'd0;
      pxX_q   <= '0;
      pxY_q   <= '0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      x_q     <= x_d;
      y_q     <= y_d;
      err_q   <= err_d;
      k_q     <= k_d;
      pxX_q   <= pxX_d;
      pxY_q   <= pxY_d;
    end
  end

  assign px_valid = (state_q == EMIT);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign px_x     = pxX_q;
  assign px_y     = pxY_q;

endmodule

// File: tb/tb_circle_plot_sequencer.sv
// Bench for circle_plot_sequencer: a plain-integer midpoint model fills a queue
// of expected pixels that a negedge monitor pops on every handshake.
module tb_circle_plot_sequencer;

  localparam int CW = 9;
  localparam int MASK = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic          start;
  logic [CW-1:0] cx, cy, radius;
  logic          abort;
  logic          busy, done, px_valid, px_ready;
  logic [CW-1:0] px_x, px_y;

  int compared;
  int mismatched;
  int expQ[$];
  bit prevStall;
  int prevXY;
  int curXY;

  circle_plot_sequencer #(.COORD_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .cx(cx), .cy(cy), .radius(radius),
    .abort(abort), .busy(busy), .done(done), .px_valid(px_valid),
    .px_ready(px_ready), .px_x(px_x), .px_y(px_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int encodePt(input int x, input int y);
    return (x & MASK) * 1000 + (y & MASK);
  endfunction

  // Expected pixel stream straight from the midpoint rules, in plain integers.
  task automatic buildCircle(input int cxv, input int cyv, input int r);
    int x, y, err;
    x = r; y = 0; err = 1 - r;
    expQ.delete();
    do begin
      expQ.push_back(encodePt(cxv + x, cyv + y));
      expQ.push_back(encodePt(cxv + x, cyv - y));
      expQ.push_back(encodePt(cxv - x, cyv + y));
      expQ.push_back(encodePt(cxv - x, cyv - y));
      expQ.push_back(encodePt(cxv + y, cyv + x));
      expQ.push_back(encodePt(cxv + y, cyv - x));
      expQ.push_back(encodePt(cxv - y, cyv + x));
      expQ.push_back(encodePt(cxv - y, cyv - x));
      y = y + 1;
      if (err < 0) err = err + 2 * y + 1;
      else begin
        x = x - 1;
        err = err + 2 * (y - x) + 1;
      end
    end while (x >= y);
  endtask

  // Monitor: every handshake must match the model; a stalled request must hold.
  always @(negedge clk) begin
    curXY = int'(px_x) * 1000 + int'(px_y);
    if (reset) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("holdValid", px_valid, 1);
        checkOutput("holdXY", curXY, prevXY);
      end
      if (px_valid && px_ready) begin
        checkOutput("pixelExpected", expQ.size() > 0, 1);
        if (expQ.size() > 0) checkOutput("pixel", curXY, expQ.pop_front());
      end
      prevStall = px_valid && !px_ready;
      prevXY    = curXY;
    end
  end

  // Caller must be just after a rising edge; start is presented immediately.
  task automatic applyStimulus(input int cxv, input int cyv, input int r,
                               input int stallAt, input int stallLen,
                               input int midStartAt, input int abortAt, input int resetAt);
    int cyc, iters, startSize;
    bit ended, sawActivity;
    buildCircle(cxv, cyv, r);
    iters = expQ.size() / 8;
    startSize = expQ.size();
    cx = CW'(cxv); cy = CW'(cyv); radius = CW'(r); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    checkOutput("busyAfterStart", busy, 1);
    ended = 1'b0;
    while (!ended) begin
      px_ready = !(stallLen > 0 && cyc >= stallAt && cyc < stallAt + stallLen);
      abort = (cyc == abortAt);
      if (cyc == midStartAt) begin
        start = 1'b1; cx = CW'(cxv + 37); cy = CW'(cyv + 11); radius = CW'(r + 3);
      end
      if (cyc == resetAt) begin
        reset = 1'b1;
        #1;
        checkOutput("asyncResetBusy", busy, 0);
        checkOutput("asyncResetDone", done, 0);
        checkOutput("asyncResetValid", px_valid, 0);
        checkOutput("asyncResetXY", int'(px_x) * 1000 + int'(px_y), 0);
        expQ.delete();
        ended = 1'b1;
      end else begin
        @(posedge clk); #1;
        cyc++;
        start = 1'b0; abort = 1'b0;
        cx = CW'(cxv); cy = CW'(cyv); radius = CW'(r);
        if (abortAt > 0 && cyc == abortAt + 1) begin
          checkOutput("abortValid", px_valid, 0);
          checkOutput("abortBusy", busy, 0);
          checkOutput("abortTransfers", startSize - expQ.size(), 4);
          expQ.delete();
          sawActivity = 1'b0;
          for (int i = 0; i < 12; i++) begin
            sawActivity |= done | px_valid | busy;
            @(posedge clk); #1;
          end
          checkOutput("abortNoDone", sawActivity, 0);
          ended = 1'b1;
        end else if (done) begin
          checkOutput("doneCycle", cyc, 9 * iters + 1 + stallLen);
          checkOutput("busyAtDone", busy, 1);
          checkOutput("pixelsLeft", expQ.size(), 0);
          @(posedge clk); #1;
          checkOutput("busyAfterDone", busy, 0);
          checkOutput("doneOnePulse", done, 0);
          ended = 1'b1;
        end else if (cyc > 3000) begin
          checkOutput("doneSeen", done, 1);
          ended = 1'b1;
        end
      end
    end
    px_ready = 1'b1;
  endtask

  int lit1[8] = '{11020, 11020, 9020, 9020, 10021, 10019, 10021, 10019};

  initial begin
    compared = 0; mismatched = 0; prevStall = 1'b0; prevXY = 0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; px_ready = 1'b1;
    cx = '0; cy = '0; radius = '0;

    // Pin the model against hand-computed pixels.
    buildCircle(10, 20, 1);
    checkOutput("modelR1Count", expQ.size(), 8);
    for (int i = 0; i < 8; i++) checkOutput("modelR1Pt", expQ[i], lit1[i]);
    buildCircle(0, 0, 3);
    checkOutput("modelR3Count", expQ.size(), 24);
    checkOutput("modelR3Wrap", expQ[2], 509000);
    checkOutput("modelR3Iter3", expQ[16], 2002);
    buildCircle(100, 100, 0);
    checkOutput("modelR0Count", expQ.size(), 8);
    expQ.delete();

    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetDone", done, 0);
    checkOutput("resetValid", px_valid, 0);
    checkOutput("resetXY", int'(px_x) * 1000 + int'(px_y), 0);
    reset = 1'b0;

    $display("[TB] radius 0 at (100,100)");
    applyStimulus(100, 100, 0, 0, 0, 0, 0, 0);
    $display("[TB] radius 1 at (10,20)");
    applyStimulus(10, 20, 1, 0, 0, 0, 0, 0);
    $display("[TB] radius 3 at origin, wrapping");
    applyStimulus(0, 0, 3, 0, 0, 0, 0, 0);
    $display("[TB] radius 5 with 5-cycle stall");
    applyStimulus(200, 150, 5, 3, 5, 0, 0, 0);
    $display("[TB] radius 6 with start pulsed while busy");
    applyStimulus(300, 40, 6, 0, 0, 5, 0, 0);
    $display("[TB] radius 7 aborted at 4th transfer");
    applyStimulus(100, 100, 7, 0, 0, 0, 4, 0);
    $display("[TB] radius 4 reset during STEP");
    applyStimulus(50, 60, 4, 0, 0, 0, 0, 9);
    @(posedge clk); #1;
    reset = 1'b0;
    $display("[TB] radius 8 right after reset release");
    applyStimulus(500, 7, 8, 0, 0, 0, 0, 0);
    $display("[TB] radius 100 at (256,256)");
    applyStimulus(256, 256, 100, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/circle_plot_sequencer.md
CIRCLE_PLOT_SEQUENCER -- requirements
Module: circle_plot_sequencer

Interface
REQ-001 Parameter: COORD_W, default 9, pixel coordinate width (512x512 pixel memory).
REQ-002 Port: clk  in  1  clock, all logic rising-edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: start  in  1  request to draw one circle; sampled only in IDLE.
REQ-005 Port: cx  in  COORD_W  centre x.
REQ-006 Port: cy  in  COORD_W  centre y.
REQ-007 Port: radius  in  COORD_W  unsigned radius.
REQ-008 Port: abort  in  1  synchronous cancel of the current circle.
REQ-009 Port: busy  out  1  high from the cycle after start acceptance through the DONE cycle, inclusive.
REQ-010 Port: done  out  1  one-cycle completion pulse.
REQ-011 Port: px_valid  out  1  pixel write request to the pixel memory port.
REQ-012 Port: px_ready  in  1  pixel memory accepts the request; transfer when px_valid and px_ready are both high.
REQ-013 Port: px_x  out  COORD_W  pixel x (memory row index).
REQ-014 Port: px_y  out  COORD_W  pixel y (memory column index).

Function
REQ-015 States: IDLE, EMIT, STEP, DONE; the SHALL use an explicit encoded state register.
REQ-016 IDLE with start=1: latch cx, cy, radius; set x=radius, y=0, err=1-radius (signed, COORD_W+3 bits); next state EMIT.
REQ-017 start in any state other than IDLE SHALL be ignored (no re-latch, no queueing).
REQ-018 EMIT: 3-bit octant counter k=0..7; px_valid=1; k advances only on handshake; handshake at k=7 -> STEP.
REQ-019 Octant k output order (px_x, px_y): 0 (cx+x, cy+y), 1 (cx+x, cy-y), 2 (cx-x, cy+y), 3 (cx-x, cy-y), 4 (cx+y, cy+x), 5 (cx+y, cy-x), 6 (cx-y, cy+x), 7 (cx-y, cy-x).
REQ-020 Coordinate arithmetic SHALL be modulo 2^COORD_W (wrap, no clipping, no saturation).
REQ-021 All 8 points SHALL be emitted every iteration, duplicates included (y=0, x=y, radius=0); no deduplication.
REQ-022 px_x, px_y SHALL be registered and held stable while px_valid=1 and px_ready=0.
REQ-023 STEP (one cycle, px_valid=0): y<=y+1; if err<0 then err<=err+2(y+1)+1, else x<=x-1 and err<=err+2((y+1)-(x-1))+1.
REQ-024 STEP exit: if updated x >= updated y -> EMIT with k=0, else -> DONE.
REQ-025 DONE: done=1, busy=1 for exactly one cycle; next state IDLE.
REQ-026 Throughput: with px_ready held high, 9 cycles per iteration (8 EMIT + 1 STEP); first px_valid in the cycle after start acceptance.
REQ-027 abort=1 in EMIT, STEP or DONE: next state IDLE, px_valid=0 next cycle, no done pulse; abort in IDLE has no effect.
REQ-028 abort and a px handshake in the same cycle: the handshake completes, then abort takes effect.
REQ-029 Total pixels per circle SHALL equal 8 times the iteration count.

Reset
REQ-030 reset=1 SHALL force IDLE immediately, including mid-circle, with busy=0, done=0, px_valid=0, px_x=0, px_y=0, k=0.
REQ-031 After reset release, the first start SHALL be honoured on the first rising edge with reset low.

Verification
REQ-032 radius=0, cx=cy=100, px_ready=1 -> 8 transfers all (100,100), done pulse 10 cycles after start edge, busy low after.
REQ-033 radius=1, cx=10, cy=20 -> exactly 8 transfers in order (11,20),(11,20),(9,20),(9,20),(10,21),(10,19),(10,21),(10,19); one iteration.
REQ-034 radius=3, cx=cy=0 -> 24 transfers, iterations (x,y)=(3,0),(3,1),(2,2); third transfer equals (509,0) (wrap).
REQ-035 radius=5, px_ready low for 5 cycles mid-EMIT -> px_valid held high, px_x/px_y unchanged, no octant skipped; total count unchanged.
REQ-036 start pulsed while busy -> ignored, original circle completes; abort at the 4th transfer -> IDLE next cycle, no done, busy=0.
REQ-037 reset asserted mid-STEP -> all outputs at reset values asynchronously; new start after release draws a full correct circle.
